// File: rtl/nios_system_sysid_ctrl.sv
// Sequencer/arbiter for the system-ID slave: post-reset self-check of the ID and
// timestamp words, then round-robin sharing of the slave between two requesters.
module nios_system_sysid_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1512962994,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  input  logic        recheck,
  input  logic        req0,
  input  logic        addr0,
  input  logic        req1,
  input  logic        addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        check_done,
  output logic        id_ok,
  output logic        ts_ok
);

  typedef enum logic [1:0] {
    CHK_ID = 2'd0,
    CHK_TS = 2'd1,
    IDLE   = 2'd2,
    ACCESS = 2'd3
  } state_t;

  localparam logic [3:0] CAPTURE_CNT = 4'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        favour_q, favour_d;
  logic        owner_q, owner_d;
  logic        pending_q, pending_d;
  logic        sysid_address_q, sysid_address_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        check_done_q, check_done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        capture_s;
  logic        pick_s;

  // Counter reloads to zero on every state entry; readdata is sampled on the
  // READ_LATENCY-th edge the address has been held.
  assign capture_s = (cnt_q == CAPTURE_CNT);
  // pick_s = 1 selects requester 1; on contention the favoured one wins.
  assign pick_s    = (req0 && req1) ? favour_q : req1;

  // Next-state and registered-output computation
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    favour_d        = favour_q;
    owner_d         = owner_q;
    pending_d       = pending_q;
    sysid_address_d = sysid_address_q;
    gnt0_d          = 1'b0;
    gnt1_d          = 1'b0;
    rvalid0_d       = 1'b0;
    rvalid1_d       = 1'b0;
    rdata_d         = rdata_q;
    check_done_d    = check_done_q;
    id_ok_d         = id_ok_q;
    ts_ok_d         = ts_ok_q;
    case (state_q)
      CHK_ID: begin
        pending_d = pending_q | recheck;
        if (capture_s) begin
          id_ok_d         = (sysid_readdata == EXPECTED_ID);
          sysid_address_d = 1'b1;
          cnt_d           = 4'd0;
          state_d         = CHK_TS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHK_TS: begin
        pending_d = pending_q | recheck;
        if (capture_s) begin
          ts_ok_d      = (sysid_readdata == EXPECTED_TS);
          check_done_d = 1'b1;
          cnt_d        = 4'd0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      IDLE: begin
        if (recheck || pending_q) begin
          pending_d       = 1'b0;
          check_done_d    = 1'b0;
          id_ok_d         = 1'b0;
          ts_ok_d         = 1'b0;
          sysid_address_d = 1'b0;
          cnt_d           = 4'd0;
          state_d         = CHK_ID;
        end else if (req0 || req1) begin
          gnt0_d          = ~pick_s;
          gnt1_d          = pick_s;
          owner_d         = pick_s;
          favour_d        = ~pick_s;
          sysid_address_d = pick_s ? addr1 : addr0;
          cnt_d           = 4'd0;
          state_d         = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        pending_d = pending_q | recheck;
        if (capture_s) begin
          rdata_d   = sysid_readdata;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
          cnt_d     = 4'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        sysid_address_d = 1'b0;
        cnt_d           = 4'd0;
        state_d         = CHK_ID;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= CHK_ID;
      cnt_q           <= 4'd0;
      favour_q        <= 1'b0;
      owner_q         <= 1'b0;
      pending_q       <= 1'b0;
      sysid_address_q <= 1'b0;
      gnt0_q          <= 1'b0;
      gnt1_q          <= 1'b0;
      rvalid0_q       <= 1'b0;
      rvalid1_q       <= 1'b0;
      rdata_q         <= 32'd0;
      check_done_q    <= 1'b0;
      id_ok_q         <= 1'b0;
      ts_ok_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      favour_q        <= favour_d;
      owner_q         <= owner_d;
      pending_q       <= pending_d;
      sysid_address_q <= sysid_address_d;
      gnt0_q          <= gnt0_d;
      gnt1_q          <= gnt1_d;
      rvalid0_q       <= rvalid0_d;
      rvalid1_q       <= rvalid1_d;
      rdata_q         <= rdata_d;
      check_done_q    <= check_done_d;
      id_ok_q         <= id_ok_d;
      ts_ok_q         <= ts_ok_d;
    end
  end

  assign sysid_address = sysid_address_q;
  assign gnt0          = gnt0_q;
  assign gnt1          = gnt1_q;
  assign rvalid0       = rvalid0_q;
  assign rvalid1       = rvalid1_q;
  assign rdata         = rdata_q;
  assign check_done    = check_done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;

endmodule
